dispatch_ctrl: RTL and testbench
================================

// Module: dispatch_ctrl
// PURPOSE
//  In-order dispatch scheduler between instruction fetch and the decoder.
//  Buffers fetched {pc,inst} pairs in an IQ_DEPTH-entry FIFO and releases at most one per cycle.
//  Releases only when ROB, RS and (memory ops only) LSB have space; each release gets a sequential ROB tag.
//  Back-pressures fetch and flushes on clear (branch mispredict).
// PARAMETERS
//  IQ_DEPTH   4  FIFO entries; power of two, >=2
//  ROB_WIDTH  4  ROB tag width; tags wrap modulo 2^ROB_WIDTH
// PORTS
//  clk_in      in   1   single clock; all state updates on posedge
//  rst_in      in   1   synchronous, active-low reset
//  rdy_in      in   1   global enable; 0 freezes every register
//  clear       in   1   flush request from ROB (mispredict)
//  if_valid    in   1   fetch offers an instruction
//  if_inst     in   32  fetched instruction word
//  if_pc       in   32  pc of fetched instruction
//  if_ready    out  1   FIFO accepts this cycle (combinational)
//  rob_full    in   1   ROB has no free entry
//  rs_full     in   1   RS has no free entry
//  lsb_full    in   1   LSB has no free entry
//  dec_valid   out  1   registered one-cycle pulse per dispatched instruction
//  dec_inst    out  32  dispatched instruction word
//  dec_pc      out  32  dispatched pc
//  dec_tag     out  ROB_WIDTH  ROB tag of dispatched instruction
//  dec_is_mem  out  1   dispatched op is a load (0000011) or store (0100011)
// BEHAVIOUR
//  Reset (rst_in=0 at posedge):
//   - FIFO empty, head/tail/count=0, tag counter=0, state=RUN.
//   - dec_valid=0; dec_inst=0, dec_pc=0, dec_tag=0, dec_is_mem=0.
//  rdy_in=0: no register changes, outputs hold; reset still takes priority.
//  FSM states RUN, STALL, FLUSH:
//   - RUN->STALL: FIFO non-empty and head blocked.
//   - STALL->RUN: in the cycle the head dispatches.
//   - any->FLUSH: clear=1.
//   - FLUSH->RUN: unconditionally after exactly one cycle.
//  Push:
//   - if_ready = (count<IQ_DEPTH) && state!=FLUSH && !clear.
//   - Entry written when if_valid && if_ready.
//  Head blocked when any of:
//   - rob_full or rs_full
//   - head is a memory op and lsb_full
//  Pop condition: FIFO non-empty, head not blocked, state!=FLUSH, clear=0.
//   - Strictly in order: a blocked head never lets younger entries bypass.
//  Pop effects, registered:
//   - next cycle dec_valid=1; dec_inst/dec_pc = head; dec_tag = tag counter.
//   - Tag counter += 1, wrapping 2^ROB_WIDTH-1 -> 0.
//   - dec_valid=0 in every cycle without a pop; dec_* data hold their last values.
//  Latency:
//   - An instruction pushed at edge N into an empty, unblocked FIFO is popped at edge N+1.
//   - dec_valid is seen high after that edge (1-cycle FIFO residency minimum).
//  Throughput: one dispatch per cycle when unblocked.
//  Push/pop in the same cycle: both occur; count unchanged.
//   - When count==IQ_DEPTH, if_ready=0 even if a pop occurs (no same-cycle full bypass).
//  Count/pointers: count is log2(IQ_DEPTH)+1 bits; head and tail wrap modulo IQ_DEPTH.
//  clear=1 at an edge (priority over push/pop, below reset):
//   - FIFO emptied, tag counter=0, dec_valid=0, state=FLUSH.
//   - No push and no pop in that cycle or in the FLUSH cycle.
//  Reset mid-stream: all in-flight entries discarded, same as the reset values above.
// TESTING
//  T1 reset: hold rst_in=0 two cycles with if_valid=1
//     -> dec_valid=0, dec_tag=0, if_ready=0 while in reset; if_ready=1 after release.
//  T2 stream: push ADDI 0x00100093 @pc 0x0, then 0x00208113 @pc 0x4 on back-to-back cycles
//     -> dec_valid on 2 consecutive cycles, tags 0,1, pcs 0x0,0x4.
//  T3 backpressure: rob_full=1, push 5 instrs
//     -> if_ready drops after the 4th accept; release rob_full
//     -> 4 dispatches in push order, tags 0..3.
//  T4 LSB stall: lsb_full=1, push LW 0x0000a103 then ADD 0x002081b3
//     -> no dispatch (ADD does not bypass); lsb_full=0
//     -> LW tag 0, then ADD tag 1.
//  T5 flush: 3 entries queued, clear=1 for one cycle
//     -> next 2 cycles dec_valid=0 and if_ready=0; then a new push dispatches with tag 0.
//  T6 wrap + freeze: dispatch 17 instrs -> 17th tag=0 (ROB_WIDTH=4);
//     rdy_in=0 mid-stream -> all outputs hold unchanged.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// dispatch_ctrl
//   In-order dispatch scheduler between instruction fetch and the decoder.
//   Fetched {pc,inst} pairs are buffered in an IQ_DEPTH-entry FIFO. At most one
//   entry is released per cycle, and only when the ROB and RS have space (and,
//   for loads/stores, the LSB too). Each released entry gets the next
//   sequential ROB tag. A clear (branch mispredict) empties the FIFO, restarts
//   tags at zero and spends one FLUSH cycle before accepting again.
//
// Handshake: a fetch transfer happens on a posedge where if_valid && if_ready
//   are both 1. if_ready is combinational and does not depend on if_valid.
//   if_valid may be raised freely and must hold its payload until accepted.
//   dec_valid is a registered one-cycle pulse per dispatch. There is no
//   decoder ready; availability comes from the *_full inputs.
//
// Ports
//   clk_in       clock, all state updates on posedge
//   rst_in       synchronous active-low reset
//   rdy_in       global enable, 0 freezes every register
//   clear        flush request (mispredict)
//   if_valid     fetch offers {if_pc, if_inst}
//   if_inst      fetched instruction word
//   if_pc        pc of fetched instruction
//   if_ready     FIFO accepts this cycle
//   rob_full     ROB has no free entry
//   rs_full      RS has no free entry
//   lsb_full     LSB has no free entry
//   dec_valid    one-cycle pulse per dispatched instruction
//   dec_inst     dispatched instruction word
//   dec_pc       dispatched pc
//   dec_tag      ROB tag of dispatched instruction
//   dec_is_mem   dispatched op is a load or store
//   dbg_state_o  FSM state (0 RUN, 1 STALL, 2 FLUSH)
// -----------------------------------------------------------------------------
module dispatch_ctrl #(
   parameter int IQ_DEPTH  = 4,
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear,
   input  logic                 if_valid,
   input  logic [31:0]          if_inst,
   input  logic [31:0]          if_pc,
   output logic                 if_ready,
   input  logic                 rob_full,
   input  logic                 rs_full,
   input  logic                 lsb_full,
   output logic                 dec_valid,
   output logic [31:0]          dec_inst,
   output logic [31:0]          dec_pc,
   output logic [ROB_WIDTH-1:0] dec_tag,
   output logic                 dec_is_mem,
   output logic [1:0]           dbg_state_o
);

   localparam int PTR_W = $clog2(IQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [ROB_WIDTH-1:0] tag_q, tag_d;

   logic                 dec_valid_q, dec_valid_d;
   logic [31:0]          dec_inst_q, dec_inst_d;
   logic [31:0]          dec_pc_q, dec_pc_d;
   logic [ROB_WIDTH-1:0] dec_tag_q, dec_tag_d;
   logic                 dec_is_mem_q, dec_is_mem_d;

   logic [31:0] fifo_inst_q [IQ_DEPTH];
   logic [31:0] fifo_pc_q   [IQ_DEPTH];

   logic [31:0] head_inst;
   logic [31:0] head_pc;
   logic        head_is_mem;
   logic        fifo_empty;
   logic        head_blocked;
   logic        push;
   logic        pop;

   assign head_inst   = fifo_inst_q[head_q];
   assign head_pc     = fifo_pc_q[head_q];
   assign head_is_mem = (head_inst[6:0] == 7'b0000011) || (head_inst[6:0] == 7'b0100011);
   assign fifo_empty  = (count_q == '0);
   assign head_blocked = rob_full || rs_full || (head_is_mem && lsb_full);

   // Gated by rst_in so fetch sees no acceptance while reset is asserted.
   // A full FIFO refuses even when a pop happens in the same cycle.
   assign if_ready = rst_in && (count_q < CNT_W'(IQ_DEPTH)) && (state_q != FLUSH) && !clear;
   assign push     = if_valid && if_ready;
   // A blocked head stalls everything behind it: strictly in order.
   assign pop      = !fifo_empty && !head_blocked && (state_q != FLUSH) && !clear;

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = FLUSH;
      end else begin
         case (state_q)
            RUN:     if (!fifo_empty && head_blocked) state_d = STALL;
            STALL:   if (pop) state_d = RUN;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      tag_d        = tag_q;
      dec_valid_d  = 1'b0;
      dec_inst_d   = dec_inst_q;
      dec_pc_d     = dec_pc_q;
      dec_tag_d    = dec_tag_q;
      dec_is_mem_d = dec_is_mem_q;
      if (clear) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         tag_d   = '0;
      end else begin
         if (push) begin
            tail_d = tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_d       = head_q + PTR_W'(1);
            tag_d        = tag_q + ROB_WIDTH'(1);
            dec_valid_d  = 1'b1;
            dec_inst_d   = head_inst;
            dec_pc_d     = head_pc;
            dec_tag_d    = tag_q;
            dec_is_mem_d = head_is_mem;
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q      <= RUN;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         tag_q        <= '0;
         dec_valid_q  <= 1'b0;
         dec_inst_q   <= '0;
         dec_pc_q     <= '0;
         dec_tag_q    <= '0;
         dec_is_mem_q <= 1'b0;
      end else if (rdy_in) begin
         state_q      <= state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         tag_q        <= tag_d;
         dec_valid_q  <= dec_valid_d;
         dec_inst_q   <= dec_inst_d;
         dec_pc_q     <= dec_pc_d;
         dec_tag_q    <= dec_tag_d;
         dec_is_mem_q <= dec_is_mem_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by count/pointers only.
   always_ff @(posedge clk_in) begin
      if (rst_in && rdy_in && push) begin
         fifo_inst_q[tail_q] <= if_inst;
         fifo_pc_q[tail_q]   <= if_pc;
      end
   end

   assign dec_valid   = dec_valid_q;
   assign dec_inst    = dec_inst_q;
   assign dec_pc      = dec_pc_q;
   assign dec_tag     = dec_tag_q;
   assign dec_is_mem  = dec_is_mem_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dispatch_ctrl
//   Self-checking bench for dispatch_ctrl. Accepted pushes are recorded in a
//   scoreboard queue with the tag and opcode class they should dispatch with;
//   a monitor pops and compares on every dispatch pulse.
// -----------------------------------------------------------------------------
module tb_dispatch_ctrl;

   localparam int ROB_W = 4;
   localparam int EW    = 32 + 32 + ROB_W + 1 + 32;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic             clk;
   logic             rst_in;
   logic             rdy_in;
   logic             clear;
   logic             if_valid;
   logic [31:0]      if_inst;
   logic [31:0]      if_pc;
   logic             if_ready;
   logic             rob_full;
   logic             rs_full;
   logic             lsb_full;
   logic             dec_valid;
   logic [31:0]      dec_inst;
   logic [31:0]      dec_pc;
   logic [ROB_W-1:0] dec_tag;
   logic             dec_is_mem;
   logic [1:0]       dbg_state;

   dispatch_ctrl #(.IQ_DEPTH(4), .ROB_WIDTH(ROB_W)) dut (
      .clk_in      (clk),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .clear       (clear),
      .if_valid    (if_valid),
      .if_inst     (if_inst),
      .if_pc       (if_pc),
      .if_ready    (if_ready),
      .rob_full    (rob_full),
      .rs_full     (rs_full),
      .lsb_full    (lsb_full),
      .dec_valid   (dec_valid),
      .dec_inst    (dec_inst),
      .dec_pc      (dec_pc),
      .dec_tag     (dec_tag),
      .dec_is_mem  (dec_is_mem),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   cyc = 0;
   logic rdy_prev = 1'b0;
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rdy_prev <= rdy_in;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic is_mem_op(input logic [31:0] inst);
      return (inst[6:0] == 7'h03) || (inst[6:0] == 7'h23);
   endfunction

   // ---------------- scoreboard ----------------
   logic [EW-1:0]    exp_q[$];
   logic [ROB_W-1:0] tag_model = '0;
   int               n_disp    = 0;
   logic             lat_chk   = 1'b0;

   always @(negedge clk) begin
      if (rdy_prev === 1'b1 && dec_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_dispatch", 64'(dec_valid), 64'd0);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            chk("dec_pc",     64'(dec_pc),     64'(e[EW-1 -: 32]));
            chk("dec_inst",   64'(dec_inst),   64'(e[EW-33 -: 32]));
            chk("dec_tag",    64'(dec_tag),    64'(e[32+1+ROB_W-1 -: ROB_W]));
            chk("dec_is_mem", 64'(dec_is_mem), 64'(e[32]));
            if (lat_chk) chk("latency", 64'(cyc - int'(e[31:0])), 64'd2);
            n_disp++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      rdy_in   = 1'b1;
      clear    = 1'b0;
      if_valid = 1'b0;
      if_inst  = '0;
      if_pc    = '0;
      rob_full = 1'b0;
      rs_full  = 1'b0;
      lsb_full = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_in = 1'b0;
      repeat (2) @(posedge clk);
      exp_q.delete();
      tag_model = '0;
      #1;
      rst_in = 1'b1;
   endtask

   // Offer one instruction until accepted; returns 1 ns after the accept edge.
   task automatic push_one(input logic [31:0] pc, input logic [31:0] inst, input int max_wait);
      logic accepted;
      accepted = 1'b0;
      if_valid = 1'b1;
      if_pc    = pc;
      if_inst  = inst;
      for (int i = 0; i < max_wait && !accepted; i++) begin
         @(negedge clk);
         if (if_ready === 1'b1 && rdy_in && rst_in) begin
            exp_q.push_back({pc, inst, tag_model, is_mem_op(inst), 32'(cyc)});
            tag_model = tag_model + 1'b1;
            accepted  = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if_valid = 1'b0;
      chk("push_accepted", 64'(accepted), 64'd1);
   endtask

   task automatic drain(input int max_wait);
      for (int i = 0; i < max_wait && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   initial begin
      int d0;
      logic [31:0]      s_inst, s_pc;
      logic [ROB_W-1:0] s_tag;
      logic             s_valid, s_mem, s_ready;
      logic [1:0]       s_state;

      idle_inputs();
      rst_in = 1'b0;

      // T1: reset held two cycles with if_valid high
      if_valid = 1'b1;
      if_inst  = 32'h00100093;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         chk("t1_rst_dec_valid", 64'(dec_valid), 64'd0);
         chk("t1_rst_dec_tag",   64'(dec_tag),   64'd0);
         chk("t1_rst_if_ready",  64'(if_ready),  64'd0);
      end
      @(posedge clk);
      #1;
      rst_in   = 1'b1;
      if_valid = 1'b0;
      @(negedge clk);
      chk("t1_rel_if_ready",  64'(if_ready),   64'd1);
      chk("t1_rel_dec_inst",  64'(dec_inst),   64'd0);
      chk("t1_rel_dec_pc",    64'(dec_pc),     64'd0);
      chk("t1_rel_dec_mem",   64'(dec_is_mem), 64'd0);
      chk("t1_rel_state",     64'(dbg_state),  64'(ST_RUN));
      @(posedge clk);
      #1;

      // T2: back-to-back stream, exact latency, tags 0,1
      do_reset();
      lat_chk = 1'b1;
      d0 = n_disp;
      push_one(32'h0, 32'h00100093, 4);
      push_one(32'h4, 32'h00208113, 4);
      drain(10);
      lat_chk = 1'b0;
      chk("t2_disp_count", 64'(n_disp - d0), 64'd2);

      // T3: ROB full back-pressure
      do_reset();
      rob_full = 1'b1;
      d0 = n_disp;
      for (int i = 0; i < 4; i++) push_one(32'h100 + 32'(i * 4), 32'h00000013 + (32'(i) << 7), 4);
      if_valid = 1'b1;
      if_pc    = 32'h110;
      if_inst  = 32'h00500293;
      repeat (3) begin
         @(negedge clk);
         chk("t3_full_if_ready", 64'(if_ready),  64'd0);
         chk("t3_blk_dec_valid", 64'(dec_valid), 64'd0);
         chk("t3_stall_state",   64'(dbg_state), 64'(ST_STALL));
         @(posedge clk);
         #1;
      end
      if_valid = 1'b0;
      rob_full = 1'b0;
      drain(20);
      chk("t3_disp_count", 64'(n_disp - d0), 64'd4);

      // T4: LSB stall, younger ALU op must not bypass
      do_reset();
      lsb_full = 1'b1;
      d0 = n_disp;
      push_one(32'h200, 32'h0000a103, 4);
      push_one(32'h204, 32'h002081b3, 4);
      repeat (3) begin
         @(negedge clk);
         chk("t4_blk_dec_valid", 64'(dec_valid), 64'd0);
         chk("t4_stall_state",   64'(dbg_state), 64'(ST_STALL));
         @(posedge clk);
         #1;
      end
      lsb_full = 1'b0;
      drain(20);
      chk("t4_disp_count", 64'(n_disp - d0), 64'd2);

      // T5: flush with three entries queued
      do_reset();
      rob_full = 1'b1;
      for (int i = 0; i < 3; i++) push_one(32'h300 + 32'(i * 4), 32'h00100093, 4);
      clear = 1'b1;
      exp_q.delete();
      tag_model = '0;
      @(negedge clk);
      chk("t5_clr_if_ready", 64'(if_ready), 64'd0);
      @(posedge clk);
      #1;
      clear    = 1'b0;
      rob_full = 1'b0;
      d0 = n_disp;
      @(negedge clk);
      chk("t5_fl_dec_valid", 64'(dec_valid), 64'd0);
      chk("t5_fl_if_ready",  64'(if_ready),  64'd0);
      chk("t5_fl_state",     64'(dbg_state), 64'(ST_FLUSH));
      @(posedge clk);
      @(negedge clk);
      chk("t5_post_dec_valid", 64'(dec_valid), 64'd0);
      chk("t5_post_if_ready",  64'(if_ready),  64'd1);
      chk("t5_post_state",     64'(dbg_state), 64'(ST_RUN));
      @(posedge clk);
      #1;
      push_one(32'h400, 32'h00300193, 4);
      drain(10);
      chk("t5_disp_count", 64'(n_disp - d0), 64'd1);

      // T6: 17 dispatches (tag wrap) with a mid-stream freeze
      do_reset();
      d0 = n_disp;
      for (int i = 0; i < 17; i++) begin
         logic [31:0] ins;
         ins = (i % 5 == 0) ? (32'h0000a003 | (32'(i % 32) << 7)) : (32'h00000013 | (32'(i % 32) << 7));
         if (i % 7 == 3) rs_full = ($urandom_range(0, 1) == 1);
         push_one(32'h1000 + 32'(i * 4), ins, 8);
         rs_full = 1'b0;
         if (i == 8) begin
            rdy_in = 1'b0;
            @(negedge clk);
            s_valid = dec_valid;
            s_inst  = dec_inst;
            s_pc    = dec_pc;
            s_tag   = dec_tag;
            s_mem   = dec_is_mem;
            s_ready = if_ready;
            s_state = dbg_state;
            repeat (3) begin
               @(negedge clk);
               chk("t6_frz_dec_valid", 64'(dec_valid),  64'(s_valid));
               chk("t6_frz_dec_inst",  64'(dec_inst),   64'(s_inst));
               chk("t6_frz_dec_pc",    64'(dec_pc),     64'(s_pc));
               chk("t6_frz_dec_tag",   64'(dec_tag),    64'(s_tag));
               chk("t6_frz_dec_mem",   64'(dec_is_mem), 64'(s_mem));
               chk("t6_frz_if_ready",  64'(if_ready),   64'(s_ready));
               chk("t6_frz_state",     64'(dbg_state),  64'(s_state));
            end
            @(posedge clk);
            #1;
            rdy_in = 1'b1;
         end
      end
      drain(40);
      chk("t6_disp_count", 64'(n_disp - d0), 64'd17);
      @(negedge clk);
      chk("t6_last_tag", 64'(dec_tag), 64'd0);

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
